// File: rtl/mem_write_checker.sv
// mem_write_checker
// Self-checking monitor for the CPU data-memory write port. It compares the
// store stream (mem_write/data_adr/write_data) against a list of NUM_EXP
// expected (address, data) pairs, in index order or in any order, and
// reports a sticky PASS or FAIL with a failure code. One scratch address can
// be ignored, and a cycle timeout catches programs that never finish.
//
// Optional build macro: MEM_WRITE_CHECKER_CAPTURE_EN
//   When defined, the outputs fail_addr/fail_data hold the offending store
//   (address and data) that caused an unexpected-address or data-mismatch
//   failure. When undefined, those ports and registers do not exist.
//
// Reset is synchronous and active-low; every output comes straight from a
// register, so there is no combinational input-to-output path.

module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT = 4096,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_write,
  input  logic [ADDR_W-1:0]           data_adr,
  input  logic [DATA_W-1:0]           write_data,
  input  logic [NUM_EXP*ADDR_W-1:0]   exp_addr_flat,
  input  logic [NUM_EXP*DATA_W-1:0]   exp_data_flat,
  input  logic                        ordered,
  input  logic                        ign_en,
  input  logic [ADDR_W-1:0]           ign_addr,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic [1:0]                  fail_code,
  output logic [NUM_EXP-1:0]          match_mask,
  output logic [CNT_W-1:0]            cycle_count
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]           fail_addr,
  output logic [DATA_W-1:0]           fail_data
`endif
);

  // Index width for the ordered-mode pointer; at least one bit.
  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_EXP - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_EXP-1:0] ALL_ONES  = {NUM_EXP{1'b1}};

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_BAD_ADDR = 2'd1;
  localparam logic [1:0] CODE_BAD_DATA = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  // Registered state and outputs
  state_t             state_r;
  logic               done_r;
  logic               pass_r;
  logic               fail_r;
  logic [1:0]         fail_code_r;
  logic [NUM_EXP-1:0] match_mask_r;
  logic [CNT_W-1:0]   cycle_count_r;
  logic [IDX_W-1:0]   ord_idx_r;
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
  logic [ADDR_W-1:0]  fail_addr_r;
  logic [DATA_W-1:0]  fail_data_r;
`endif

  // Combinational decision signals
  logic               store_s;
  logic [NUM_EXP-1:0] addr_eq_s;
  logic [NUM_EXP-1:0] data_eq_s;
  logic [NUM_EXP-1:0] ord_onehot_s;
  logic               ord_addr_eq_s;
  logic               ord_data_eq_s;
  logic [NUM_EXP-1:0] cand_s;
  logic [NUM_EXP-1:0] cand_onehot_s;
  logic               addr_only_s;
  logic               ev_match_s;
  logic               ev_last_s;
  logic               ev_fail_s;
  logic [1:0]         ev_code_s;
  logic [NUM_EXP-1:0] mask_next_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               timeout_s;

  // A store counts only when strobed and not aimed at the ignored scratch address.
  assign store_s = mem_write & ~(ign_en & (data_adr == ign_addr));

  // Per-entry address and data equality against the current store.
  always_comb begin
    addr_eq_s = {NUM_EXP{1'b0}};
    data_eq_s = {NUM_EXP{1'b0}};
    for (int i = 0; i < NUM_EXP; i++) begin
      addr_eq_s[i] = (data_adr == exp_addr_flat[i*ADDR_W +: ADDR_W]);
      data_eq_s[i] = (write_data == exp_data_flat[i*DATA_W +: DATA_W]);
    end
  end

  // Ordered mode looks only at the entry selected by the pointer.
  assign ord_onehot_s  = NUM_EXP'(1) << ord_idx_r;
  assign ord_addr_eq_s = |(addr_eq_s & ord_onehot_s);
  assign ord_data_eq_s = |(data_eq_s & ord_onehot_s);

  // Any-order mode: unmatched full hits, isolated to the lowest index so a
  // store consumes one entry even when the list holds duplicates.
  assign cand_s        = ~match_mask_r & addr_eq_s & data_eq_s;
  assign cand_onehot_s = cand_s & (~cand_s + NUM_EXP'(1));
  assign addr_only_s   = |(~match_mask_r & addr_eq_s);

  // Classify the current store as match, final match or failure with a code.
  always_comb begin
    ev_match_s  = 1'b0;
    ev_last_s   = 1'b0;
    ev_fail_s   = 1'b0;
    ev_code_s   = CODE_NONE;
    mask_next_s = match_mask_r;
    if (ordered) begin
      if (ord_addr_eq_s && ord_data_eq_s) begin
        ev_match_s  = 1'b1;
        mask_next_s = match_mask_r | ord_onehot_s;
        ev_last_s   = (ord_idx_r == LAST_IDX);
      end else if (ord_addr_eq_s) begin
        ev_fail_s = 1'b1;
        ev_code_s = CODE_BAD_DATA;
      end else begin
        ev_fail_s = 1'b1;
        ev_code_s = CODE_BAD_ADDR;
      end
    end else begin
      if (|cand_s) begin
        ev_match_s  = 1'b1;
        mask_next_s = match_mask_r | cand_onehot_s;
        ev_last_s   = (mask_next_s == ALL_ONES);
      end else if (addr_only_s) begin
        ev_fail_s = 1'b1;
        ev_code_s = CODE_BAD_DATA;
      end else begin
        ev_fail_s = 1'b1;
        ev_code_s = CODE_BAD_ADDR;
      end
    end
  end

  // Saturating RUN-cycle counter and timeout detection on the reaching edge.
  always_comb begin
    if (cycle_count_r == TIMEOUT_C) begin
      cnt_next_s = cycle_count_r;
    end else begin
      cnt_next_s = cycle_count_r + CNT_W'(1);
    end
    timeout_s = (cnt_next_s == TIMEOUT_C);
  end

  // Checker state machine; store outcomes take priority over the timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      fail_code_r   <= CODE_NONE;
      match_mask_r  <= {NUM_EXP{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
      ord_idx_r     <= {IDX_W{1'b0}};
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
      fail_addr_r   <= {ADDR_W{1'b0}};
      fail_data_r   <= {DATA_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_RUN: begin
          cycle_count_r <= cnt_next_s;
          if (store_s && ev_fail_s) begin
            state_r     <= ST_FAIL;
            done_r      <= 1'b1;
            fail_r      <= 1'b1;
            fail_code_r <= ev_code_s;
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
            fail_addr_r <= data_adr;
            fail_data_r <= write_data;
`endif
          end else begin
            if (store_s && ev_match_s) begin
              match_mask_r <= mask_next_s;
              if (ordered) begin
                ord_idx_r <= ord_idx_r + IDX_W'(1);
              end else begin
                ord_idx_r <= ord_idx_r;
              end
            end
            if (store_s && ev_match_s && ev_last_s) begin
              state_r <= ST_PASS;
              done_r  <= 1'b1;
              pass_r  <= 1'b1;
            end else if (timeout_s) begin
              state_r     <= ST_FAIL;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= CODE_TIMEOUT;
            end
          end
        end
        ST_PASS, ST_FAIL: begin
          // Terminal states hold every register until reset.
          state_r <= state_r;
        end
        default: begin
          // Unreachable encoding: report a failure rather than a false pass.
          state_r <= ST_FAIL;
          done_r  <= 1'b1;
          pass_r  <= 1'b0;
          fail_r  <= 1'b1;
        end
      endcase
    end
  end

  assign done        = done_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign fail_code   = fail_code_r;
  assign match_mask  = match_mask_r;
  assign cycle_count = cycle_count_r;
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
  assign fail_addr   = fail_addr_r;
  assign fail_data   = fail_data_r;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three instances (1, 3 and 2 entries) share one
// store bus; a behavioural model of the selected instance predicts outputs.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        ordered;
  logic        ign_en;
  logic [31:0] ign_addr;

  logic [31:0] ea [0:15];
  logic [31:0] ed [0:15];

  logic [31:0] e1_addr, e1_data;
  logic [95:0] e3_addr, e3_data;
  logic [63:0] et_addr, et_data;

  always_comb begin
    e1_addr = ea[0];
    e1_data = ed[0];
    e3_addr = {ea[2], ea[1], ea[0]};
    e3_data = {ed[2], ed[1], ed[0]};
    et_addr = {ea[1], ea[0]};
    et_data = {ed[1], ed[0]};
  end

  logic        u1_done, u1_pass, u1_fail;
  logic [1:0]  u1_code;
  logic [0:0]  u1_mask;
  logic [12:0] u1_cnt;
  logic        u3_done, u3_pass, u3_fail;
  logic [1:0]  u3_code;
  logic [2:0]  u3_mask;
  logic [8:0]  u3_cnt;
  logic        ut_done, ut_pass, ut_fail;
  logic [1:0]  ut_code;
  logic [1:0]  ut_mask;
  logic [3:0]  ut_cnt;
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
  logic [31:0] u1_fa, u1_fd, u3_fa, u3_fd, ut_fa, ut_fd;
`endif

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .TIMEOUT(4096)) u1 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .exp_addr_flat(e1_addr), .exp_data_flat(e1_data),
    .ordered(ordered), .ign_en(ign_en), .ign_addr(ign_addr),
    .done(u1_done), .pass(u1_pass), .fail(u1_fail), .fail_code(u1_code),
    .match_mask(u1_mask), .cycle_count(u1_cnt)
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    , .fail_addr(u1_fa), .fail_data(u1_fd)
`endif
  );

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(3), .TIMEOUT(300)) u3 (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .exp_addr_flat(e3_addr), .exp_data_flat(e3_data),
    .ordered(ordered), .ign_en(ign_en), .ign_addr(ign_addr),
    .done(u3_done), .pass(u3_pass), .fail(u3_fail), .fail_code(u3_code),
    .match_mask(u3_mask), .cycle_count(u3_cnt)
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    , .fail_addr(u3_fa), .fail_data(u3_fd)
`endif
  );

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .TIMEOUT(10)) ut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .exp_addr_flat(et_addr), .exp_data_flat(et_data),
    .ordered(ordered), .ign_en(ign_en), .ign_addr(ign_addr),
    .done(ut_done), .pass(ut_pass), .fail(ut_fail), .fail_code(ut_code),
    .match_mask(ut_mask), .cycle_count(ut_cnt)
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    , .fail_addr(ut_fa), .fail_data(ut_fd)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: state 0 = running, 1 = passed, 2 = failed
  int          sel;
  int          m_n, m_t, m_state, m_k, m_cnt, m_code;
  logic [15:0] m_mask;
  logic [31:0] m_fa, m_fd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_cnt = 0; m_code = 0;
    m_mask = 16'h0; m_fa = 32'h0; m_fd = 32'h0;
  endtask

  task automatic model_fail(input int code, input logic [31:0] a, input logic [31:0] d);
    m_state = 2;
    m_code  = code;
    m_fa    = a;
    m_fd    = d;
  endtask

  task automatic model_step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    int hit;
    bit addr_seen;
    bit all_set;
    if (m_state != 0) return;
    if (m_cnt < m_t) m_cnt++;
    if (mw && !(ign_en && a == ign_addr)) begin
      if (ordered) begin
        if (a == ea[m_k] && d == ed[m_k]) begin
          m_mask[m_k] = 1'b1;
          m_k++;
          if (m_k == m_n) m_state = 1;
        end else begin
          model_fail((a == ea[m_k]) ? 2 : 1, a, d);
        end
      end else begin
        hit = -1;
        addr_seen = 1'b0;
        for (int i = 0; i < m_n; i++) begin
          if (!m_mask[i] && a == ea[i]) begin
            addr_seen = 1'b1;
            if (hit < 0 && d == ed[i]) hit = i;
          end
        end
        if (hit >= 0) begin
          m_mask[hit] = 1'b1;
          all_set = 1'b1;
          for (int i = 0; i < m_n; i++) if (!m_mask[i]) all_set = 1'b0;
          if (all_set) m_state = 1;
        end else begin
          model_fail(addr_seen ? 2 : 1, a, d);
        end
      end
    end
    if (m_state == 0 && m_cnt == m_t) begin
      m_state = 2;
      m_code  = 3;
    end
  endtask

  task automatic compare_all(input string where);
    logic [63:0] od, op, of, oc, om, on;
    case (sel)
      1: begin od = 64'(u1_done); op = 64'(u1_pass); of = 64'(u1_fail);
               oc = 64'(u1_code); om = 64'(u1_mask); on = 64'(u1_cnt); end
      3: begin od = 64'(u3_done); op = 64'(u3_pass); of = 64'(u3_fail);
               oc = 64'(u3_code); om = 64'(u3_mask); on = 64'(u3_cnt); end
      default: begin od = 64'(ut_done); op = 64'(ut_pass); of = 64'(ut_fail);
               oc = 64'(ut_code); om = 64'(ut_mask); on = 64'(ut_cnt); end
    endcase
    check($sformatf("%s.done", where), od, 64'(m_state != 0));
    check($sformatf("%s.pass", where), op, 64'(m_state == 1));
    check($sformatf("%s.fail", where), of, 64'(m_state == 2));
    check($sformatf("%s.code", where), oc, 64'(m_code));
    check($sformatf("%s.mask", where), om, 64'(m_mask));
    check($sformatf("%s.cnt", where), on, 64'(m_cnt));
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    case (sel)
      1: begin check($sformatf("%s.faddr", where), 64'(u1_fa), 64'(m_fa));
               check($sformatf("%s.fdata", where), 64'(u1_fd), 64'(m_fd)); end
      3: begin check($sformatf("%s.faddr", where), 64'(u3_fa), 64'(m_fa));
               check($sformatf("%s.fdata", where), 64'(u3_fd), 64'(m_fd)); end
      default: begin check($sformatf("%s.faddr", where), 64'(ut_fa), 64'(m_fa));
               check($sformatf("%s.fdata", where), 64'(ut_fd), 64'(m_fd)); end
    endcase
`endif
  endtask

  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input string where);
    mem_write  = mw;
    data_adr   = a;
    write_data = d;
    @(posedge clk);
    #1;
    model_step(mw, a, d);
    compare_all(where);
  endtask

  task automatic do_reset(input string where);
    reset     = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    compare_all(where);
    reset = 1'b1;
  endtask

  task automatic use_dut(input int s, input int n, input int t);
    sel = s; m_n = n; m_t = t;
  endtask

  initial begin
    int r;
    int j;
    reset = 1'b1; mem_write = 1'b0; data_adr = 32'h0; write_data = 32'h0;
    ordered = 1'b1; ign_en = 1'b1; ign_addr = 32'd96;
    for (int i = 0; i < 16; i++) begin ea[i] = 32'h0; ed[i] = 32'h0; end
    ea[0] = 32'd100; ed[0] = 32'd7;
    use_dut(1, 1, 4096);
    model_reset();

    // Single entry: ignored scratch stores, then the expected store
    do_reset("s1.rst");
    step(1'b1, 32'd96, 32'd3, "s1.ign0");
    step(1'b1, 32'd96, 32'd9, "s1.ign1");
    step(1'b1, 32'd100, 32'd7, "s1.hit");
    check("s1.pass_const", 64'(u1_pass), 64'd1);
    check("s1.code_const", 64'(u1_code), 64'd0);
    step(1'b1, 32'd104, 32'd1, "s1.frozen");

    // Data mismatch
    do_reset("s2.rst");
    step(1'b1, 32'd100, 32'd8, "s2.bad");
    check("s2.code_const", 64'(u1_code), 64'd2);
`ifdef MEM_WRITE_CHECKER_CAPTURE_EN
    check("s2.faddr_const", 64'(u1_fa), 64'd100);
    check("s2.fdata_const", 64'(u1_fd), 64'd8);
`endif

    // Unexpected address; later correct store cannot recover
    do_reset("s3.rst");
    step(1'b1, 32'd104, 32'd7, "s3.bad");
    step(1'b1, 32'd100, 32'd7, "s3.late");
    check("s3.code_const", 64'(u1_code), 64'd1);

    // Three entries, any order
    ea[0] = 32'd100; ed[0] = 32'd7;
    ea[1] = 32'd104; ed[1] = 32'd25;
    ea[2] = 32'd108; ed[2] = 32'd1;
    ordered = 1'b0; ign_en = 1'b0;
    use_dut(3, 3, 300);
    do_reset("s4.rst");
    step(1'b1, 32'd108, 32'd1, "s4.a");
    step(1'b0, 32'd104, 32'd99, "s4.idle");
    step(1'b1, 32'd100, 32'd7, "s4.b");
    check("s4.mask_const", 64'(u3_mask), 64'h5);
    step(1'b1, 32'd104, 32'd25, "s4.c");
    check("s4.pass_const", 64'(u3_pass), 64'd1);

    // Reset from PASS, then the sequence passes again
    do_reset("s4.rerst");
    step(1'b1, 32'd108, 32'd1, "s4.ra");
    step(1'b1, 32'd100, 32'd7, "s4.rb");
    step(1'b1, 32'd104, 32'd25, "s4.rc");

    // Repeat store to an already-matched address
    do_reset("s5.rst");
    step(1'b1, 32'd100, 32'd7, "s5.a");
    step(1'b1, 32'd100, 32'd7, "s5.dup");
    check("s5.code_const", 64'(u3_code), 64'd1);

    // Ordered mode rejects out-of-order first store
    ordered = 1'b1;
    do_reset("s6.rst");
    step(1'b1, 32'd108, 32'd1, "s6.bad");
    check("s6.code_const", 64'(u3_code), 64'd1);

    // Timeout with no stores
    ea[0] = 32'd100; ed[0] = 32'd7;
    ea[1] = 32'd104; ed[1] = 32'd25;
    ordered = 1'b1; ign_en = 1'b0;
    use_dut(2, 2, 10);
    do_reset("t1.rst");
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 32'd0, $sformatf("t1.c%0d", i));
    check("t1.code_const", 64'(ut_code), 64'd3);
    check("t1.cnt_const", 64'(ut_cnt), 64'd10);
    step(1'b0, 32'd0, 32'd0, "t1.frozen");

    // Final match on the timeout edge wins
    do_reset("t2.rst");
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd0, $sformatf("t2.c%0d", i));
    step(1'b1, 32'd100, 32'd7, "t2.m0");
    step(1'b1, 32'd104, 32'd25, "t2.m1");
    check("t2.pass_const", 64'(ut_pass), 64'd1);

    // Mismatch on the timeout edge reports the mismatch
    do_reset("t3.rst");
    for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 32'd0, $sformatf("t3.c%0d", i));
    step(1'b1, 32'd200, 32'd0, "t3.bad");
    check("t3.code_const", 64'(ut_code), 64'd1);

    // Randomized runs on the three-entry instance
    use_dut(3, 3, 300);
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 3; i++) begin
        ea[i] = 32'(4 * $urandom_range(0, 5));
        ed[i] = 32'($urandom_range(0, 2));
      end
      ordered  = 1'($urandom_range(0, 1));
      ign_en   = 1'($urandom_range(0, 1));
      ign_addr = 32'(4 * $urandom_range(0, 5));
      do_reset($sformatf("r%0d.rst", it));
      for (int c = 0; c < 12; c++) begin
        r = int'($urandom_range(0, 9));
        if (r < 2) begin
          step(1'b0, 32'($urandom), 32'($urandom), $sformatf("r%0d.c%0d", it, c));
        end else if (r < 7) begin
          if (ordered && m_k < m_n) j = m_k;
          else j = int'($urandom_range(0, 2));
          step(1'b1, ea[j], ed[j], $sformatf("r%0d.c%0d", it, c));
        end else begin
          step(1'b1, 32'(4 * $urandom_range(0, 5)), 32'($urandom_range(0, 2)),
               $sformatf("r%0d.c%0d", it, c));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
